// File: rtl/spi_master_ctrl_pkg.sv
// rtl/spi_master_ctrl_pkg.sv - shared types and constants for the SPI master controller
//
// Purpose : controller state encoding, data width and bit-counter width,
//           imported by the interface, the PISO and the controller top.
// Ports   : none (package).

package spi_pkg;

    localparam int SPI_DATA_W = 8;
    localparam int SPI_CNT_W  = 3;

    // Counter value of the last SHIFT cycle and of the one before it.
    localparam logic [SPI_CNT_W-1:0] SPI_CNT_LAST = '1;
    localparam logic [SPI_CNT_W-1:0] SPI_CNT_PRE  = SPI_CNT_LAST - SPI_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } spi_state_t;

endpackage

// File: rtl/spi_master_ctrl_if.sv
// rtl/spi_master_ctrl_if.sv - upstream byte handshake bundle of the SPI master controller
//
// Purpose : groups the byte request / byte result signals between the
//           upstream client and the controller.
// Signals : tx_valid, tx_data  - byte request from the client
//           tx_ready           - controller can accept a byte
//           rx_valid, rx_data  - one-cycle pulse with the received byte
//           busy               - controller not idle
// Modports: master - the upstream client
//           slave  - the controller (spi_master_ctrl)

interface spi_master_ctrl_if;
    import spi_pkg::*;

    logic                  tx_valid;
    logic [SPI_DATA_W-1:0] tx_data;
    logic                  tx_ready;
    logic                  rx_valid;
    logic [SPI_DATA_W-1:0] rx_data;
    logic                  busy;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready,
        input  rx_valid,
        input  rx_data,
        input  busy
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready,
        output rx_valid,
        output rx_data,
        output busy
    );

endinterface

// File: rtl/spi_master_ctrl_piso.sv
// rtl/spi_master_ctrl_piso.sv - parallel-in serial-out TX shift register, MSB first
//
// Purpose : holds the byte being transmitted; sout is the current MSB.
//           Zeros shift in from the bottom, so after a full byte has been
//           shifted out the register (and sout) is zero again.
// Ports   : clk, rst_n - clock, asynchronous active-low reset
//           load       - capture din (has priority over shift)
//           shift      - shift one bit towards the MSB
//           din        - parallel byte
//           sout       - serial output (register MSB)

module piso
    import spi_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  shift,
    input  logic [SPI_DATA_W-1:0] din,
    output logic                  sout
);

    logic [SPI_DATA_W-1:0] sreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= din;
        end else if (shift) begin
            sreg <= {sreg[SPI_DATA_W-2:0], 1'b0};
        end
    end

    assign sout = sreg[SPI_DATA_W-1];

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI master byte controller driving an external SIPO
//
// Purpose : accepts a byte over the handshake bundle, frames it with cs_n,
//           shifts it out MSB first on mosi and collects the reply byte from
//           the downstream SIPO (rx_shift), reporting it with a rx_valid pulse.
// Ports   : clk, rst_n - SPI bit clock, asynchronous active-low reset
//           bus        - spi_master_ctrl_if.slave (tx_valid/tx_data/tx_ready,
//                        rx_valid/rx_data, busy)
//           miso       - serial bit from the slave (also feeds the SIPO)
//           rx_shift   - parallel output of the SIPO
//           shift_en   - SIPO shift enable; low clears the SIPO
//           mosi, cs_n - serial data and active-low select to the slave
// Config  : SPI_CTRL_BURST_EN - when defined, a new byte can be handed over in
//           the last SHIFT cycle and is shifted back-to-back without
//           releasing cs_n.

module spi_master_ctrl
    import spi_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    spi_master_ctrl_if.slave      bus,
    input  logic                  miso,
    input  logic [SPI_DATA_W-1:0] rx_shift,
    output logic                  shift_en,
    output logic                  mosi,
    output logic                  cs_n
);

    spi_state_t            state;
    logic [SPI_CNT_W-1:0]  cnt;
    logic                  ready_reg;
    logic                  rx_valid_reg;
    logic [SPI_DATA_W-1:0] rx_data_reg;
    logic                  busy_reg;

    logic accept;
    logic piso_shift;

    assign accept     = bus.tx_valid && ready_reg;
    assign piso_shift = (state == ST_SHIFT);

    // The SIPO's top bit falls off on the capture edge and is never needed.
    logic rx_top_unused;
    assign rx_top_unused = rx_shift[SPI_DATA_W-1];

    piso u_piso (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .shift (piso_shift),
        .din   (bus.tx_data),
        .sout  (mosi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            ready_reg    <= 1'b1;
            cs_n         <= 1'b1;
            shift_en     <= 1'b0;
            rx_valid_reg <= 1'b0;
            rx_data_reg  <= '0;
            busy_reg     <= 1'b0;
        end else begin
            rx_valid_reg <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_SETUP;
                        cnt       <= '0;
                        cs_n      <= 1'b0;
                        ready_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                    end
                end

                ST_SETUP: begin
                    state    <= ST_SHIFT;
                    shift_en <= 1'b1;
                end

                ST_SHIFT: begin
                    cnt <= cnt + SPI_CNT_W'(1);
`ifdef SPI_CTRL_BURST_EN
                    // Open the handover window for the last bit cycle.
                    if (cnt == SPI_CNT_PRE) begin
                        ready_reg <= 1'b1;
                    end
`endif
                    if (cnt == SPI_CNT_LAST) begin
                        // The SIPO shifts miso in on this same edge and is
                        // cleared once shift_en drops, so the byte is built
                        // here from its pre-edge contents plus the live bit.
                        rx_data_reg  <= {rx_shift[SPI_DATA_W-2:0], miso};
                        rx_valid_reg <= 1'b1;
`ifdef SPI_CTRL_BURST_EN
                        if (accept) begin
                            ready_reg <= 1'b0;
                            cnt       <= '0;
                        end else begin
                            state     <= ST_DONE;
                            shift_en  <= 1'b0;
                            cs_n      <= 1'b1;
                            ready_reg <= 1'b0;
                        end
`else
                        state     <= ST_DONE;
                        shift_en  <= 1'b0;
                        cs_n      <= 1'b1;
                        ready_reg <= 1'b0;
`endif
                    end
                end

                ST_DONE: begin
                    state     <= ST_IDLE;
                    ready_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                end

                default: begin
                    state     <= ST_IDLE;
                    ready_reg <= 1'b1;
                    cs_n      <= 1'b1;
                    shift_en  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_ready = ready_reg;
    assign bus.rx_valid = rx_valid_reg;
    assign bus.rx_data  = rx_data_reg;
    assign bus.busy     = busy_reg;

endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, SPI bit clock (5 MHz); all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port tx_valid, input, 1, upstream byte-request valid.
REQ-004 SHALL have port tx_data, input, 8, byte to transmit, MSB first.
REQ-005 SHALL have port tx_ready, output, 1, controller can accept a byte.
REQ-006 SHALL have port miso, input, 1, serial bit from slave, same wire that feeds the SIPO.
REQ-007 SHALL have port rx_shift, input, 8, parallel output of the downstream SIPO.
REQ-008 SHALL have port shift_en, output, 1, shift enable to the SIPO; low clears the SIPO.
REQ-009 SHALL have port mosi, output, 1, serial bit to slave.
REQ-010 SHALL have port cs_n, output, 1, active-low slave select.
REQ-011 SHALL have port rx_valid, output, 1, one-cycle pulse: rx_data holds a new byte.
REQ-012 SHALL have port rx_data, output, 8, last received byte.
REQ-013 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, SETUP, SHIFT, DONE; all outputs registered.
REQ-015 IDLE: tx_ready=1, cs_n=1, shift_en=0, mosi=0; on tx_valid&&tx_ready, load tx shift register and 3-bit counter=0, go SETUP.
REQ-016 SETUP (1 cycle): cs_n=0, mosi=tx_data[7], shift_en asserted at the edge leaving SETUP; go SHIFT.
REQ-017 SHIFT (8 cycles, counter 0..7): shift_en=1, cs_n=0; in cycle k mosi=tx bit 7-k; counter increments each edge.
REQ-018 At the edge ending SHIFT cycle 7, SHALL register rx_data={rx_shift[6:0], miso} (the SIPO's post-edge value, captured here because shift_en falling clears the SIPO) and assert rx_valid for exactly one cycle.
REQ-019 Without burst (REQ-027), after cycle 7 go DONE: shift_en=0, cs_n=1, mosi=0, tx_ready=0; next edge go IDLE.
REQ-020 Latency: accept edge to rx_valid high = 9 cycles; accept edge to tx_ready high again = 10 cycles.
REQ-021 tx_valid outside the accept window SHALL be ignored; tx_data sampled only on the accept edge.
REQ-022 rx_data SHALL hold its value until the next capture.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, tx_ready=1, cs_n=1, shift_en=0, mosi=0, rx_valid=0, rx_data=8'h00, busy=0, counter=0.
REQ-024 Reset mid-transfer SHALL abort without an rx_valid pulse; first accept is possible on the first edge after rst_n rises.

Configuration
REQ-025 Macro SPI_CTRL_BURST_EN SHALL select back-to-back transfers.
REQ-026 Without SPI_CTRL_BURST_EN, tx_ready SHALL be high only in IDLE.
REQ-027 With SPI_CTRL_BURST_EN, tx_ready SHALL also be high in SHIFT cycle 7; a handshake there reloads tx register and counter, stays in SHIFT, keeps shift_en=1 and cs_n=0 continuously, and still pulses rx_valid for the completed byte; no handshake falls through to DONE as in REQ-019.

Structure
REQ-028 Package spi_pkg SHALL hold the state enum (spi_state_t), SPI_DATA_W=8 and the counter width.
REQ-029 The TX shift register SHALL be a sub-module piso (load, shift, serial out, MSB first).

Verification
REQ-030 Reset: assert rst_n=0 mid-idle -> cs_n=1, shift_en=0, tx_ready=1, rx_valid=0, rx_data=8'h00.
REQ-031 Single byte: tx_data=8'hA5, slave model returns 8'h3C -> mosi 1,0,1,0,0,1,0,1 over SHIFT; rx_data=8'h3C, rx_valid one cycle, 9 cycles after accept.
REQ-032 Busy reject (burst off): tx_valid=1 with tx_data=8'h11 during SHIFT -> no accept; accepted in IDLE 10 cycles after the first accept.
REQ-033 Reset mid-SHIFT at counter=4 -> outputs at reset values in the same cycle, no rx_valid, SIPO cleared via shift_en=0.
REQ-034 Burst (SPI_CTRL_BURST_EN): 8'h81 then 8'h7E, slave returns 8'hF0, 8'h0F -> cs_n low for 17 continuous cycles, shift_en high 16 cycles, rx_valid pulses 8 cycles apart with 8'hF0 then 8'h0F.
REQ-035 Edge data: miso constant 1 -> rx_data=8'hFF; constant 0 -> 8'h00.
